// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - control/status and pin bundle for the 7-segment display controller
interface seg7_display_ctrl_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 16
);
    logic                  load;
    logic [BIN_WIDTH-1:0]  value;
    logic                  enable;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport master (
        output load, value, enable,
        input  busy, done, overflow, seg, an
    );

    modport slave (
        input  load, value, enable,
        output busy, done, overflow, seg, an
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multiplexed N-digit 7-segment driver with iterative binary-to-BCD
module seg7_display_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int BIN_WIDTH    = 16,
    parameter int REFRESH_BITS = 17,
    parameter int BLANK_LZ     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    seg7_display_ctrl_if.slave  disp
);
    localparam int STORE_W = 4 * NUM_DIGITS;
    // One extra nibble above the displayed digits catches values too big to show.
    localparam int SCR_W   = 4 * (NUM_DIGITS + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_t;

    state_t                  state_q;
    logic [BIN_WIDTH-1:0]    shift_q;
    logic [SCR_W-1:0]        scratch_q;
    logic [SCR_W-1:0]        scratch_adj;
    logic [SCR_W-1:0]        scratch_d;
    logic                    carry_out;
    logic                    sticky_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [STORE_W-1:0]      store_q;
    logic                    ovf_q;
    logic                    busy_q;
    logic                    done_q;

    logic [REFRESH_BITS-1:0] dwell_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic [NUM_DIGITS-1:0]   upper_nz;
    logic                    nz_acc;
    logic [3:0]              digit_sel;
    logic                    blank;
    logic [6:0]              seg_q;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [NUM_DIGITS-1:0]   an_d;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = SEG_OFF;
        endcase
    endfunction

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary bit.
    always_comb begin
        scratch_adj = scratch_q;
        for (int n = 0; n <= NUM_DIGITS; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                scratch_adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end
        end
        scratch_d = {scratch_adj[SCR_W-2:0], shift_q[BIN_WIDTH-1]};
        carry_out = scratch_adj[SCR_W-1];
    end

    // Conversion FSM; the display store only changes in COMMIT so the old value stays visible.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            bit_cnt_q <= '0;
            store_q   <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (disp.load) begin
                        shift_q   <= disp.value;
                        scratch_q <= '0;
                        sticky_q  <= 1'b0;
                        bit_cnt_q <= CNT_W'(BIN_WIDTH - 1);
                        busy_q    <= 1'b1;
                        state_q   <= S_CONV;
                    end
                end
                S_CONV: begin
                    shift_q   <= shift_q << 1;
                    scratch_q <= scratch_d;
                    // A bit falling off the top means the value outgrew even the spare nibble.
                    sticky_q  <= sticky_q | carry_out;
                    if (bit_cnt_q == '0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                S_COMMIT: begin
                    store_q <= scratch_q[STORE_W-1:0];
                    ovf_q   <= sticky_q | (scratch_q[SCR_W-1 -: 4] != 4'd0);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next scan slot, leading-zero mask and segment pattern for the digit about to be driven.
    always_comb begin
        idx_d = idx_q;
        if (&dwell_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        nz_acc   = 1'b0;
        upper_nz = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_acc      = nz_acc | (store_q[4*i +: 4] != 4'd0);
            upper_nz[i] = nz_acc;
        end
        digit_sel = store_q[4*int'(idx_d) +: 4];
        blank     = (BLANK_LZ != 0) && (idx_d != '0) && !upper_nz[idx_d];
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_OFF;
        end else begin
            seg_d = decode(digit_sel);
        end
        an_d = disp.enable ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    end

    // Free-running dwell counter and registered digit/anode outputs; scan continues while dark.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dwell_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= '1;
        end else begin
            dwell_q <= dwell_q + 1'b1;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign disp.busy     = busy_q;
    assign disp.done     = done_q;
    assign disp.overflow = ovf_q;
    assign disp.seg      = seg_q;
    assign disp.an       = an_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - scoreboard bench for seg7_display_ctrl in three configurations
module tb_seg7_display_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_display_ctrl_if #(.NUM_DIGITS(8), .BIN_WIDTH(16)) if8 ();
    seg7_display_ctrl_if #(.NUM_DIGITS(3), .BIN_WIDTH(16)) if3 ();
    seg7_display_ctrl_if #(.NUM_DIGITS(8), .BIN_WIDTH(16)) if8n ();

    seg7_display_ctrl #(.NUM_DIGITS(8), .BIN_WIDTH(16), .REFRESH_BITS(3), .BLANK_LZ(1))
        u8 (.clk_i(clk), .rst_i(rst), .disp(if8));
    seg7_display_ctrl #(.NUM_DIGITS(3), .BIN_WIDTH(16), .REFRESH_BITS(3), .BLANK_LZ(1))
        u3 (.clk_i(clk), .rst_i(rst), .disp(if3));
    seg7_display_ctrl #(.NUM_DIGITS(8), .BIN_WIDTH(16), .REFRESH_BITS(3), .BLANK_LZ(0))
        u8n (.clk_i(clk), .rst_i(rst), .disp(if8n));

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          w;
        int          v;
        logic [55:0] segs;
        bit          ovf;
    } exp_t;
    exp_t sb[$];

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: dec7 = 7'b1000000;  1: dec7 = 7'b1111001;  2: dec7 = 7'b0100100;
            3: dec7 = 7'b0110000;  4: dec7 = 7'b0011001;  5: dec7 = 7'b0010010;
            6: dec7 = 7'b0000010;  7: dec7 = 7'b1111000;  8: dec7 = 7'b0000000;
            9: dec7 = 7'b0010000;  default: dec7 = 7'b1111111;
        endcase
    endfunction

    function automatic int nd_of(input int w);
        return (w == 1) ? 3 : 8;
    endfunction

    function automatic exp_t make_exp(input int w, input int v);
        exp_t   e;
        longint lim = 1;
        longint p   = 1;
        int     nd  = nd_of(w);
        bit     blk = (w != 2);
        for (int k = 0; k < nd; k++) lim = lim * 10;
        e.w = w; e.v = v; e.segs = '1; e.ovf = (v >= lim);
        for (int i = 0; i < nd; i++) begin
            if (e.ovf)                       e.segs[i*7 +: 7] = 7'b0111111;
            else if (blk && i > 0 && v < p)  e.segs[i*7 +: 7] = 7'b1111111;
            else                             e.segs[i*7 +: 7] = dec7(int'((v / p) % 10));
            p = p * 10;
        end
        return e;
    endfunction

    function automatic logic [7:0] an_of(input int w);
        case (w)
            0:       return if8.an;
            1:       return {5'b11111, if3.an};
            default: return if8n.an;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input int w);
        case (w)
            0:       return if8.seg;
            1:       return if3.seg;
            default: return if8n.seg;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? if8.busy : (w == 1) ? if3.busy : if8n.busy;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? if8.done : (w == 1) ? if3.done : if8n.done;
    endfunction

    function automatic logic ovf_of(input int w);
        return (w == 0) ? if8.overflow : (w == 1) ? if3.overflow : if8n.overflow;
    endfunction

    task automatic drive(input int w, input logic ld, input int v);
        case (w)
            0:       begin if8.load  = ld; if8.value  = 16'(v); end
            1:       begin if3.load  = ld; if3.value  = 16'(v); end
            default: begin if8n.load = ld; if8n.value = 16'(v); end
        endcase
    endtask

    task automatic start_load(input int w, input int v);
        @(negedge clk);
        drive(w, 1'b1, v);
        @(negedge clk);
        drive(w, 1'b0, v);
    endtask

    task automatic wait_done(input int w, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (done_of(w) === 1'b1) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic grab(input int w, input int d, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s  = 'x;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (an_of(w) === ~(8'd1 << d)) begin
                ok = 1'b1;
                s  = seg_of(w);
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] s;
        logic [7:0] prev;
        bit ok;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (if8.an !== 8'hFF || if8.seg !== 7'h7F || if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: an=%b seg=%b busy=%b done=%b ovf=%b, need an=11111111 seg=1111111 busy=0 done=0 ovf=0",
                     if8.an, if8.seg, if8.busy, if8.done, if8.overflow);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            grab(0, i, s, ok);
            tests++;
            if (!ok || s !== ((i == 0) ? 7'b1000000 : 7'b1111111)) begin
                fails++;
                $display("FAIL reset_digit%0d: seen=%0d seg=%b need %b", i, ok, s, (i == 0) ? 7'b1000000 : 7'b1111111);
            end
        end
        prev = an_of(0);
        for (int k = 0; k < 50 && an_of(0) === prev; k++) @(negedge clk);
        prev = an_of(0);
        n = 0;
        for (int k = 0; k < 50 && an_of(0) === prev; k++) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != 8 || an_of(0) !== {prev[6:0], prev[7]}) begin
            fails++;
            $display("FAIL scan_dwell: dwell=%0d next_an=%b, need dwell=8 next_an=%b", n, an_of(0), {prev[6:0], prev[7]});
        end
    endtask

    task automatic test_convert();
        exp_t e;
        logic [6:0] s;
        bit ok;
        int busy_cnt, done_k, done_cnt;
        int vals[4] = '{0, 65535, 10, 9};
        sb.push_back(make_exp(0, 511));
        start_load(0, 511);
        busy_cnt = 0; done_k = -1; done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy_of(0) === 1'b1) busy_cnt++;
            if (done_of(0) === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            @(negedge clk);
        end
        tests++;
        if (busy_cnt != 17 || done_k != 17 || done_cnt != 1) begin
            fails++;
            $display("FAIL conv_timing: busy_cycles=%0d done_at=%0d done_pulses=%0d, need 17/17/1", busy_cnt, done_k, done_cnt);
        end
        for (int t = -1; t < 4; t++) begin
            if (t >= 0) begin
                sb.push_back(make_exp(0, vals[t]));
                start_load(0, vals[t]);
                wait_done(0, ok);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL conv_done_timeout: value=%0d got no done, need done", vals[t]);
                end
            end
            e = sb.pop_front();
            tests++;
            if (ovf_of(0) !== e.ovf) begin
                fails++;
                $display("FAIL conv_ovf value=%0d: got %b need %b", e.v, ovf_of(0), e.ovf);
            end
            for (int i = 0; i < 8; i++) begin
                grab(0, i, s, ok);
                tests++;
                if (!ok || s !== e.segs[i*7 +: 7]) begin
                    fails++;
                    $display("FAIL conv value=%0d digit%0d: seen=%0d seg=%b need %b", e.v, i, ok, s, e.segs[i*7 +: 7]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        logic [6:0] s;
        bit ok;
        int vals[6] = '{1000, 42, 999, 10000, 65535, 0};
        for (int t = 0; t < 6; t++) begin
            sb.push_back(make_exp(1, vals[t]));
            start_load(1, vals[t]);
            wait_done(1, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || ovf_of(1) !== e.ovf) begin
                fails++;
                $display("FAIL ovf3 value=%0d: done=%0d ovf=%b need done=1 ovf=%b", e.v, ok, ovf_of(1), e.ovf);
            end
            for (int i = 0; i < 3; i++) begin
                grab(1, i, s, ok);
                tests++;
                if (!ok || s !== e.segs[i*7 +: 7]) begin
                    fails++;
                    $display("FAIL ovf3 value=%0d digit%0d: seen=%0d seg=%b need %b", e.v, i, ok, s, e.segs[i*7 +: 7]);
                end
            end
        end
    endtask

    task automatic test_no_blank();
        exp_t e;
        logic [6:0] s;
        bit ok;
        int vals[3] = '{7, 0, 12345};
        for (int t = 0; t < 3; t++) begin
            sb.push_back(make_exp(2, vals[t]));
            start_load(2, vals[t]);
            wait_done(2, ok);
            e = sb.pop_front();
            for (int i = 0; i < 8; i++) begin
                grab(2, i, s, ok);
                tests++;
                if (!ok || s !== e.segs[i*7 +: 7]) begin
                    fails++;
                    $display("FAIL noblank value=%0d digit%0d: seen=%0d seg=%b need %b", e.v, i, ok, s, e.segs[i*7 +: 7]);
                end
            end
        end
    endtask

    task automatic test_load_during_conv();
        exp_t e;
        logic [6:0] s;
        bit ok;
        int extra;
        sb.push_back(make_exp(0, 300));
        start_load(0, 300);
        repeat (4) @(negedge clk);
        drive(0, 1'b1, 999);
        @(negedge clk);
        drive(0, 1'b0, 0);
        wait_done(0, ok);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy_of(0) !== 1'b0) extra++;
            @(negedge clk);
        end
        tests++;
        if (!ok || extra != 0) begin
            fails++;
            $display("FAIL ignore_load: done=%0d busy_after=%0d, need done=1 busy_after=0", ok, extra);
        end
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            grab(0, i, s, ok);
            tests++;
            if (!ok || s !== e.segs[i*7 +: 7]) begin
                fails++;
                $display("FAIL ignore_load digit%0d: seen=%0d seg=%b need %b", i, ok, s, e.segs[i*7 +: 7]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [6:0] s;
        bit ok;
        @(negedge clk);
        drive(0, 1'b1, 42);
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (done_of(0) === 1'b1) ok = 1'b1;
        end
        tests++;
        if (!ok || busy_of(0) !== 1'b0) begin
            fails++;
            $display("FAIL b2b_commit: done=%0d busy=%b, need done=1 busy=0", ok, busy_of(0));
        end
        drive(0, 1'b1, 77);
        sb.push_back(make_exp(0, 77));
        @(negedge clk);
        drive(0, 1'b0, 77);
        tests++;
        if (busy_of(0) !== 1'b1) begin
            fails++;
            $display("FAIL b2b_reload: busy=%b need 1", busy_of(0));
        end
        wait_done(0, ok);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            grab(0, i, s, ok);
            tests++;
            if (!ok || s !== e.segs[i*7 +: 7]) begin
                fails++;
                $display("FAIL b2b digit%0d: seen=%0d seg=%b need %b", i, ok, s, e.segs[i*7 +: 7]);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] prev;
        logic [7:0] want;
        int d;
        prev = an_of(0);
        for (int k = 0; k < 50 && an_of(0) === prev; k++) @(negedge clk);
        prev = an_of(0);
        d = 0;
        for (int i = 0; i < 8; i++) if (prev[i] === 1'b0) d = i;
        if8.enable = 1'b0;
        @(negedge clk);
        tests++;
        if (if8.an !== 8'hFF) begin
            fails++;
            $display("FAIL enable_off: an=%b need 11111111", if8.an);
        end
        repeat (18) @(negedge clk);
        tests++;
        if (if8.an !== 8'hFF) begin
            fails++;
            $display("FAIL enable_stay_off: an=%b need 11111111", if8.an);
        end
        if8.enable = 1'b1;
        @(negedge clk);
        want = ~(8'd1 << ((d + 2) % 8));
        tests++;
        if (if8.an !== want) begin
            fails++;
            $display("FAIL enable_resume: an=%b need %b", if8.an, want);
        end
    endtask

    task automatic test_reset_mid_conv();
        exp_t e;
        logic [6:0] s;
        bit ok;
        int dones;
        start_load(0, 1234);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.push_back(make_exp(0, 0));
        #1;
        tests++;
        if (if8.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_busy: busy=%b need 0", if8.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (if8.done !== 1'b0) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL rst_mid_done: done pulses=%0d need 0", dones);
        end
        e = sb.pop_front();
        for (int i = 0; i < 8; i++) begin
            grab(0, i, s, ok);
            tests++;
            if (!ok || s !== e.segs[i*7 +: 7]) begin
                fails++;
                $display("FAIL rst_mid digit%0d: seen=%0d seg=%b need %b", i, ok, s, e.segs[i*7 +: 7]);
            end
        end
    endtask

    initial begin
        if8.load = 1'b0;  if8.value = '0;  if8.enable = 1'b1;
        if3.load = 1'b0;  if3.value = '0;  if3.enable = 1'b1;
        if8n.load = 1'b0; if8n.value = '0; if8n.enable = 1'b1;
        test_reset();
        test_convert();
        test_overflow();
        test_no_blank();
        test_load_during_conv();
        test_back_to_back();
        test_enable();
        test_reset_mid_conv();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
